serial_fulladd: RTL and testbench
=================================

Name: serial_fulladd

Overview:
- Bit-serial WIDTH-bit adder with carry-in. It is the additive counterpart of the team's parallel full subtractor.
- It processes one bit per clock, LSB first, through a single full-adder cell and a carry flip-flop.
- A start/busy/done handshake frames each operation.
- It sits in the arithmetic library for area-constrained datapaths where latency of WIDTH cycles is acceptable.

Parameters:
- WIDTH, 4, operand and sum width in bits (legal range 1 to 32).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous, active-low reset, sampled on rising clk.
- start  input  1  request a new addition; sampled only when idle.
- a  input  WIDTH  operand A, captured on the accepted start edge.
- b  input  WIDTH  operand B, captured on the accepted start edge.
- cin  input  1  carry-in, captured on the accepted start edge.
- busy  output  1  high while an addition is in progress.
- done  output  1  single-cycle pulse; sum and carry are valid from this cycle.
- sum  output  WIDTH  result bits, registered and held until the next completion.
- carry  output  1  carry-out, registered and held with sum.

Behaviour:
- Reset: rst_n low at a rising edge forces the following, regardless of state:
  - state <= IDLE
  - busy = 0, done = 0, sum = 0, carry = 0
  - internal shift registers, bit counter and carry FF cleared
- Reset mid-operation aborts the addition. No done is produced and prior results are lost.
- States: IDLE and RUN.
- IDLE:
  - On a rising edge with start = 1: load shift_a <= a, shift_b <= b, carry FF <= cin, bit counter <= 0, busy <= 1, then go to RUN.
  - With start = 0: remain in IDLE, outputs hold.
- RUN, each rising edge:
  - Full-add shift_a[0], shift_b[0] and the carry FF: s = a0 ^ b0 ^ c, cout = a0&b0 | a0&c | b0&c.
  - Shift s into the MSB of the internal sum shift register; shift shift_a and shift_b right by 1.
  - Carry FF <= cout; counter increments.
- Completion, on the edge that processes bit WIDTH-1:
  - sum <= completed sum register; carry <= final cout
  - done <= 1 for exactly one cycle; busy <= 0; state <= IDLE
- Latency: start sampled at edge 0; bits are processed at edges 1 through WIDTH; done and the new sum/carry are visible after edge WIDTH.
- Throughput: one operation per WIDTH+1 cycles at best, because the next start can be accepted in the done cycle.
- start while busy is ignored. Operands are not re-captured and the current operation is unaffected.
- start in the done cycle is accepted, since the state is already IDLE. busy rises on that edge and done falls.
- Changes to a, b or cin after the capture edge have no effect on the current result.
- Arithmetic rule: {carry, sum} == a + b + cin, computed at WIDTH+1 bits with no truncation beyond that. Maximum result is 2^(WIDTH+1)-1.
- The sum and carry outputs never show partial results. They change only on a completion edge or on reset.
- WIDTH = 1 degenerates to one RUN cycle; done follows one edge after start.

Test Plan:
- WIDTH=4, a=5, b=3, cin=0, start pulsed 1 cycle -> busy high 4 cycles; done after edge 4; sum=8, carry=0.
- a=15, b=1, cin=0 -> sum=0, carry=1. Then a=15, b=15, cin=1 -> sum=15, carry=1; both held until the next done.
- Start asserted every cycle continuously, a=7, b=9, cin=1 -> operations complete with done on every 5th cycle; sum=1, carry=1 each time; no start accepted while busy.
- Start, then a/b changed to 0 during RUN and start re-pulsed mid-run -> result still reflects the captured operands; no extra done pulse.
- rst_n driven low at RUN edge 2 of a=9, b=9 -> next cycle busy=0, done=0, sum=0, carry=0; no done follows. A subsequent start with a=2, b=2 -> sum=4.
- 200 random a/b/cin operations, checked by scoreboard -> {carry,sum} equals a+b+cin for each; exactly one done per accepted start.

Source files
------------

// File: rtl/serial_fulladd.sv
// Bit-serial WIDTH-bit adder with carry-in: one full-adder cell and a carry flip-flop,
// one bit per clock LSB first, framed by a start/busy/done handshake.
module serial_fulladd #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  state_t state, state_nxt;

  logic [WIDTH-1:0] shift_a;
  logic [WIDTH-1:0] shift_b;
  logic [WIDTH-1:0] shift_s;
  logic [WIDTH-1:0] sum_nxt;
  logic [CW-1:0]    cnt;
  logic             cff;
  logic             s_bit;
  logic             c_bit;
  logic             last;

  assign s_bit = shift_a[0] ^ shift_b[0] ^ cff;
  assign c_bit = (shift_a[0] & shift_b[0]) | (shift_a[0] & cff) | (shift_b[0] & cff);
  assign last  = (cnt == LAST);

  // New sum bit enters at the MSB; written as a shift/or so WIDTH = 1 needs no special case.
  assign sum_nxt = (shift_s >> 1) | (WIDTH'(s_bit) << (WIDTH - 1));

  assign busy = (state == RUN);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last)  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shift_a <= '0;
      shift_b <= '0;
      shift_s <= '0;
      cnt     <= '0;
      cff     <= 1'b0;
      sum     <= '0;
      carry   <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            shift_a <= a;
            shift_b <= b;
            shift_s <= '0;
            cff     <= cin;
            cnt     <= '0;
          end
        end
        RUN: begin
          shift_a <= shift_a >> 1;
          shift_b <= shift_b >> 1;
          shift_s <= sum_nxt;
          cff     <= c_bit;
          cnt     <= cnt + 1'b1;
          // Outputs are only ever loaded here, so partial sums never reach the ports.
          if (last) begin
            sum   <= sum_nxt;
            carry <= c_bit;
            done  <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_fulladd.sv
// Scoreboard bench for serial_fulladd: a transaction-level model predicts accepts, done
// timing and {carry,sum} = a+b+cin; a negedge monitor checks the DUT against it.
module tb_serial_fulladd;

  localparam int W = 4;
  typedef logic [W:0] res_t;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         carry;

  logic start1, a1, b1, cin1, busy1, done1, sum1, carry1;

  int   checks = 0;
  int   errors = 0;
  int   pending = 0;
  bit   exp_done = 0;
  bit   armed = 0;
  int   done_total = 0;
  int   accepts = 0;
  int   aborts = 0;
  res_t held = '0;
  res_t q[$];

  serial_fulladd #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .cin(cin),
    .busy(busy), .done(done), .sum(sum), .carry(carry)
  );

  serial_fulladd #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1), .cin(cin1),
    .busy(busy1), .done(done1), .sum(sum1), .carry(carry1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Reference model: an operation is a WIDTH-cycle busy window; the result is plain addition.
  always @(posedge clk) begin
    if (!rst_n) begin
      if (pending > 0) aborts++;
      pending  = 0;
      exp_done = 0;
      q.delete();
      held  = '0;
      armed = 1;
    end else begin
      exp_done = 0;
      if (pending > 0) begin
        pending--;
        if (pending == 0) exp_done = 1;
      end else if (start) begin
        q.push_back(res_t'(a) + res_t'(b) + res_t'(cin));
        accepts++;
        pending = W;
      end
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      check("busy", busy, pending > 0);
      check("done", done, exp_done);
      if (done === 1'b1) begin
        done_total++;
        if (q.size() == 0) check("unexpected done", 1, 0);
        else held = q.pop_front();
      end
      check("result", {carry, sum}, held);
    end
  end

  task automatic applyStimulus(input logic [W-1:0] va, input logic [W-1:0] vb, input logic vc);
    @(posedge clk); #2;
    a = va; b = vb; cin = vc; start = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
  endtask

  task automatic waitDone(input string name, output int n);
    bit found = 0;
    n = 0;
    while (!found && n < 3 * W + 5) begin
      @(negedge clk);
      n++;
      if (done === 1'b1) found = 1;
    end
    check({name, " done seen"}, found, 1);
  endtask

  task automatic checkOutput(input string name, input logic [W-1:0] es, input logic ec,
                             input int lat);
    int n;
    waitDone(name, n);
    check({name, " latency"}, n, lat);
    check({name, " sum"}, sum, es);
    check({name, " carry"}, carry, ec);
  endtask

  initial begin
    int base;
    int n;
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    start1 = 1'b0; a1 = 1'b0; b1 = 1'b0; cin1 = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset sum", sum, 0);
    check("reset carry", carry, 0);

    applyStimulus(4'd5, 4'd3, 1'b0);
    checkOutput("5+3", 4'd8, 1'b0, W + 1);
    applyStimulus(4'd15, 4'd1, 1'b0);
    checkOutput("15+1", 4'd0, 1'b1, W + 1);
    applyStimulus(4'd15, 4'd15, 1'b1);
    checkOutput("15+15+1", 4'd15, 1'b1, W + 1);
    repeat (6) @(posedge clk);
    #1;
    check("hold sum", sum, 15);
    check("hold carry", carry, 1);

    // start held high: accepted at the done cycle, so one result every W+1 edges
    @(posedge clk); #2;
    a = 4'd7; b = 4'd9; cin = 1'b1; start = 1'b1;
    base = done_total;
    repeat (15) @(posedge clk);
    #2 start = 1'b0;
    repeat (3) @(posedge clk);
    check("continuous done count", done_total - base, 3);
    check("continuous sum", sum, 1);
    check("continuous carry", carry, 1);

    applyStimulus(4'd6, 4'd5, 1'b0);
    base = done_total;
    a = '0; b = '0; cin = 1'b1; start = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
    checkOutput("captured operands", 4'd11, 1'b0, W);
    repeat (8) @(posedge clk);
    check("single done", done_total - base, 1);

    applyStimulus(4'd9, 4'd9, 1'b0);
    @(posedge clk); #2 rst_n = 1'b0;
    @(posedge clk); #2 rst_n = 1'b1;
    @(negedge clk);
    check("abort busy", busy, 0);
    check("abort done", done, 0);
    check("abort sum", sum, 0);
    check("abort carry", carry, 0);
    base = done_total;
    repeat (8) @(posedge clk);
    check("no done after abort", done_total - base, 0);
    applyStimulus(4'd2, 4'd2, 1'b0);
    checkOutput("2+2", 4'd4, 1'b0, W + 1);

    for (int i = 0; i < 8; i++) begin
      logic [1:0] e1;
      @(posedge clk); #2;
      a1 = i[0]; b1 = i[1]; cin1 = i[2]; start1 = 1'b1;
      @(posedge clk); #2;
      start1 = 1'b0;
      check("w1 busy", busy1, 1);
      e1 = 2'(i[0]) + 2'(i[1]) + 2'(i[2]);
      @(posedge clk); #1;
      check("w1 done", done1, 1);
      check("w1 result", {carry1, sum1}, e1);
      @(posedge clk); #1;
      check("w1 done low", done1, 0);
    end

    for (int k = 0; k < 200; k++) begin
      applyStimulus(W'($urandom_range(0, 2**W - 1)), W'($urandom_range(0, 2**W - 1)),
                    1'($urandom_range(0, 1)));
      waitDone("random", n);
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end

    repeat (W + 3) @(posedge clk);
    check("one done per accepted start", done_total, accepts - aborts);
    check("scoreboard drained", q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
